// File: rtl/ethernet_frame_rx.sv
// rtl/ethernet_frame_rx.sv - Ethernet receive framer: preamble/SFD detect, header capture,
// FCS-stripping payload stream, CRC-32 check and length checks.
module ethernet_frame_rx #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [47:0] dest_mac,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic        hdr_valid,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic [10:0] payload_count,
  output logic        frame_done,
  output logic        fcs_ok,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, MAC_DEST, MAC_SOURCE, TYPE, DATA, DROP
  } state_t;

  localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t      r_state, w_state_next;
  logic [3:0]  r_pre_cnt;
  logic [2:0]  r_field_cnt;
  logic [47:0] r_dest_sh, r_src_sh;
  logic [7:0]  r_type_hi;
  logic [7:0]  r_dly [4];
  logic [2:0]  r_dly_cnt;
  logic [31:0] r_crc;
  logic [10:0] r_byte_cnt;
  logic        r_drop_report;
  logic        r_armed;

  logic        w_sfd, w_hdr_byte, w_data_byte, w_overflow;
  logic        w_done, w_done_data, w_hdr_load, w_field_last;
  logic [10:0] w_cnt_inc;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign w_cnt_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_sfd        = 1'b0;
    w_hdr_byte   = 1'b0;
    w_data_byte  = 1'b0;
    w_overflow   = 1'b0;
    w_done       = 1'b0;
    w_done_data  = 1'b0;
    w_hdr_load   = 1'b0;
    w_field_last = 1'b0;
    case (r_state)
      // r_armed stays low after reset until the line goes idle, so a frame cut by reset is dropped
      IDLE: if (rx_valid) w_state_next = (r_armed && rx_data == 8'h55) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!rx_valid)               w_state_next = IDLE;
        else if (rx_data == 8'h55) begin
          if (r_pre_cnt >= 4'd7)     w_state_next = DROP;
        end else if (rx_data == 8'hD5) begin
          w_state_next = MAC_DEST;
          w_sfd        = 1'b1;
        end else                     w_state_next = DROP;
      end
      MAC_DEST, MAC_SOURCE, TYPE: begin
        w_field_last = (r_state == TYPE) ? (r_field_cnt == 3'd1) : (r_field_cnt == 3'd5);
        if (!rx_valid) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_hdr_byte = 1'b1;
          if (w_field_last) begin
            case (r_state)
              MAC_DEST:   w_state_next = MAC_SOURCE;
              MAC_SOURCE: w_state_next = TYPE;
              default: begin
                w_state_next = DATA;
                w_hdr_load   = 1'b1;
              end
            endcase
          end
        end
      end
      DATA: begin
        if (!rx_valid) begin
          w_done       = 1'b1;
          w_done_data  = 1'b1;
          w_state_next = IDLE;
        end else if (w_cnt_inc > MAX_L) begin
          w_overflow   = 1'b1;
          w_state_next = DROP;
        end else begin
          w_data_byte = 1'b1;
        end
      end
      DROP: if (!rx_valid) begin
        w_done       = r_drop_report;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre_cnt     <= '0;
      r_field_cnt   <= '0;
      r_dest_sh     <= '0;
      r_src_sh      <= '0;
      r_type_hi     <= '0;
      for (int i = 0; i < 4; i++) r_dly[i] <= '0;
      r_dly_cnt     <= '0;
      r_crc         <= '0;
      r_byte_cnt    <= '0;
      r_drop_report <= 1'b0;
      r_armed       <= 1'b0;
      dest_mac      <= '0;
      src_mac       <= '0;
      eth_type      <= '0;
      hdr_valid     <= 1'b0;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      payload_count <= '0;
      frame_done    <= 1'b0;
      fcs_ok        <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      hdr_valid     <= w_hdr_load;
      frame_done    <= w_done;
      fcs_ok        <= w_done_data && (r_crc == CRC_RESIDUE);
      frame_err     <= w_done && (!w_done_data || r_byte_cnt < MIN_L);
      payload_valid <= 1'b0;
      if (!rx_valid) r_armed <= 1'b1;
      if (r_state == IDLE)          r_pre_cnt <= 4'd1;
      else if (r_state == PREAMBLE) r_pre_cnt <= r_pre_cnt + 4'd1;
      if (w_overflow)               r_drop_report <= 1'b1;
      else if (r_state == IDLE)     r_drop_report <= 1'b0;
      if (w_sfd) begin
        r_crc         <= 32'hFFFFFFFF;
        r_byte_cnt    <= '0;
        r_field_cnt   <= '0;
        r_dly_cnt     <= '0;
        payload_count <= '0;
      end
      if (w_hdr_byte || w_data_byte) begin
        r_crc      <= crc_next(r_crc, rx_data);
        r_byte_cnt <= w_cnt_inc;
      end
      if (w_hdr_byte) begin
        r_field_cnt <= w_field_last ? 3'd0 : r_field_cnt + 3'd1;
        if (r_state == MAC_DEST)   r_dest_sh <= {r_dest_sh[39:0], rx_data};
        if (r_state == MAC_SOURCE) r_src_sh  <= {r_src_sh[39:0], rx_data};
        if (r_state == TYPE)       r_type_hi <= rx_data;
      end
      if (w_hdr_load) begin
        dest_mac <= r_dest_sh;
        src_mac  <= r_src_sh;
        eth_type <= {r_type_hi, rx_data};
      end
      // The newest four bytes are held back; whatever remains at end of frame is the FCS
      if (w_data_byte) begin
        r_dly[0] <= rx_data;
        r_dly[1] <= r_dly[0];
        r_dly[2] <= r_dly[1];
        r_dly[3] <= r_dly[2];
        if (r_dly_cnt == 3'd4) begin
          payload_valid <= 1'b1;
          payload_data  <= r_dly[3];
          payload_count <= payload_count + 11'd1;
        end else begin
          r_dly_cnt <= r_dly_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ethernet_frame_rx.sv
// tb/tb_ethernet_frame_rx.sv - directed, table-driven bench for ethernet_frame_rx.
module tb_ethernet_frame_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type;
  logic        hdr_valid, payload_valid, frame_done, fcs_ok, frame_err;
  logic [7:0]  payload_data;
  logic [10:0] payload_count;

  ethernet_frame_rx #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type), .hdr_valid(hdr_valid),
    .payload_data(payload_data), .payload_valid(payload_valid), .payload_count(payload_count),
    .frame_done(frame_done), .fcs_ok(fcs_ok), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         npay;
    int         seed;
    logic [15:0] typ;
    bit         flip;
    bit         exp_fcs;
    bit         exp_err;
    int         exp_pcnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int first_pv_cyc = -1;
  int done_cnt = 0, hdr_cnt = 0, good_cnt = 0;
  logic        last_fcs, last_err;
  logic [10:0] last_pcnt;
  logic [47:0] cap_dest, cap_src;
  logic [15:0] cap_type;
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  vec_t        vecs[7];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (payload_valid) begin
      rx_q.push_back(payload_data);
      if (first_pv_cyc < 0) first_pv_cyc = cyc;
    end
    if (hdr_valid) begin
      hdr_cnt++;
      cap_dest = dest_mac;
      cap_src  = src_mac;
      cap_type = eth_type;
    end
    if (frame_done) begin
      done_cnt++;
      last_fcs  = fcs_ok;
      last_err  = frame_err;
      last_pcnt = payload_count;
      if (fcs_ok && !frame_err) good_cnt++;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] crc_bitwise(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ (((r[0] ^ b[i]) != 1'b0) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic build_frame(input int npay, input int seed, input logic [15:0] typ, input bit flip);
    logic [7:0]  body[$];
    logic [31:0] crc;
    logic [47:0] d, s;
    d = 48'h010203040506;
    s = 48'h0A0B0C0D0E0F;
    tx_q  = {};
    exp_q = {};
    for (int i = 0; i < 7; i++) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) body.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(s[i*8 +: 8]);
    body.push_back(typ[15:8]);
    body.push_back(typ[7:0]);
    for (int i = 0; i < npay; i++) begin
      body.push_back(8'((seed + i) & 255));
      exp_q.push_back(8'((seed + i) & 255));
    end
    crc = 32'hFFFFFFFF;
    foreach (body[i]) crc = crc_bitwise(crc, body[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) body.push_back(crc[i*8 +: 8]);
    if (flip) body[body.size()-1] = body[body.size()-1] ^ 8'h10;
    foreach (body[i]) tx_q.push_back(body[i]);
  endtask

  task automatic send_q(input int mark);
    for (int i = 0; i < tx_q.size(); i++) begin
      @(posedge clock); #1;
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      if (i == mark) accept_cyc = cyc + 1;
    end
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic clear_mon();
    rx_q = {};
    done_cnt = 0;
    hdr_cnt = 0;
    good_cnt = 0;
    first_pv_cyc = -1;
  endtask

  task automatic wait_done(input int want);
    for (int k = 0; k < 40 && done_cnt < want; k++) @(negedge clock);
    check("frame_done_count", done_cnt, want);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_payload(input string nm, input int n_req);
    int bad;
    bad = 0;
    check({nm, "_len"}, rx_q.size(), n_req);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
    check({nm, "_bytes"}, bad, 0);
  endtask

  task automatic check_hdr(input logic [15:0] typ);
    check("hdr_valid_count", hdr_cnt, 1);
    check("dest_mac", cap_dest, 48'h010203040506);
    check("src_mac", cap_src, 48'h0A0B0C0D0E0F);
    check("eth_type", cap_type, typ);
  endtask

  initial begin
    vecs[0] = '{46,   0, 16'h0800, 1'b0, 1'b1, 1'b0, 46};
    vecs[1] = '{46,   0, 16'h0800, 1'b1, 1'b0, 1'b0, 46};
    vecs[2] = '{32,   5, 16'h86DD, 1'b0, 1'b1, 1'b1, 32};
    vecs[3] = '{45,   9, 16'h0806, 1'b0, 1'b1, 1'b1, 45};
    vecs[4] = '{100, 17, 16'h0800, 1'b0, 1'b1, 1'b0, 100};
    vecs[5] = '{0,    0, 16'h0000, 1'b0, 1'b1, 1'b1, 0};
    vecs[6] = '{1500, 3, 16'h0800, 1'b0, 1'b1, 1'b0, 1500};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_payload_valid", payload_valid, 0);
    check("rst_payload_data", payload_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_fcs_ok_err", {fcs_ok, frame_err}, 0);
    check("rst_macs", {dest_mac, src_mac, eth_type}, 0);
    check("rst_payload_count", payload_count, 0);

    for (int v = 0; v < 7; v++) begin
      clear_mon();
      build_frame(vecs[v].npay, vecs[v].seed, vecs[v].typ, vecs[v].flip);
      send_q(22);
      wait_done(1);
      check("fcs_ok", last_fcs, vecs[v].exp_fcs);
      check("frame_err", last_err, vecs[v].exp_err);
      check("payload_count", last_pcnt, vecs[v].exp_pcnt);
      check_payload("payload", vecs[v].exp_pcnt);
      check_hdr(vecs[v].typ);
      if (vecs[v].npay > 0) check("payload_latency", first_pv_cyc - accept_cyc, 4);
      idle(2);
    end

    // oversize: 1600 bytes dest..FCS
    clear_mon();
    build_frame(1582, 7, 16'h0800, 1'b0);
    send_q(22);
    wait_done(1);
    check("ovr_fcs_ok", last_fcs, 0);
    check("ovr_frame_err", last_err, 1);
    check("ovr_payload_count", last_pcnt, 1500);
    check_payload("ovr_payload", 1500);
    idle(2);

    // bad preamble 55 55 57, then 8x55 + D5, then a good frame
    clear_mon();
    tx_q = '{8'h55, 8'h55, 8'h57, 8'h01, 8'h02, 8'h03};
    send_q(-1);
    idle(3);
    tx_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03};
    send_q(-1);
    idle(3);
    check("badpre_no_done", done_cnt, 0);
    check("badpre_no_hdr", hdr_cnt, 0);
    build_frame(46, 0, 16'h0800, 1'b0);
    send_q(22);
    wait_done(1);
    check("after_badpre_fcs_err", {last_fcs, last_err}, 2'b10);
    check_payload("after_badpre", 46);
    idle(2);

    // header truncated after 5 destination bytes
    clear_mon();
    tx_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
             8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_q(-1);
    wait_done(1);
    check("hdr_abort_fcs_err", {last_fcs, last_err}, 2'b01);
    check("hdr_abort_no_hdr", hdr_cnt, 0);
    idle(2);

    // back-to-back with a single idle cycle
    clear_mon();
    build_frame(46, 0, 16'h0800, 1'b0);
    send_q(-1);
    build_frame(50, 40, 16'h0800, 1'b0);
    send_q(-1);
    wait_done(2);
    check("b2b_good_frames", good_cnt, 2);
    check("b2b_payload_total", rx_q.size(), 96);
    idle(2);

    // reset during payload byte 20, remaining bytes keep arriving
    clear_mon();
    build_frame(46, 0, 16'h0800, 1'b0);
    for (int i = 0; i < tx_q.size(); i++) begin
      @(posedge clock); #1;
      if (i == 44) begin
        check("midrst_outputs",
              {hdr_valid, payload_valid, payload_data, frame_done, fcs_ok, frame_err, payload_count},
              0);
        check("midrst_hdr_regs", {dest_mac, src_mac, eth_type}, 0);
        clear_mon();
      end
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      reset    = (i == 42 || i == 43);
    end
    @(posedge clock); #1;
    rx_valid = 1'b0;
    idle(5);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_payload", rx_q.size(), 0);
    check("midrst_no_hdr", hdr_cnt, 0);
    build_frame(46, 0, 16'h0800, 1'b0);
    send_q(-1);
    wait_done(1);
    check("midrst_next_fcs_err", {last_fcs, last_err}, 2'b10);
    check_payload("midrst_next", 46);
    check_hdr(16'h0800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
